// File: rtl/ucaspian_mc_pkg.sv
// ----------------------------------------------------------------------------
// ucaspian_mc_pkg
//
// Purpose:
//   Types and helpers shared by the multi-core router and its output-fire
//   FIFO: width calculations, the fire event record and the input FSM states.
//
// Contents:
//   calc_sel_w      - bits needed to index NUM_CORES cores
//   calc_gaddr_w    - global address width (core select + local address)
//   fire_evt_t      - {sel, addr} record stored in the output FIFO; fields
//                     are sized for the largest supported configuration and
//                     users take the low bits they need
//   in_state_t      - input path FSM states
// ----------------------------------------------------------------------------
package ucaspian_mc_pkg;

    localparam int MAX_SEL_W       = 4;
    localparam int MAX_CORE_ADDR_W = 16;

    function automatic int calc_sel_w(input int num_cores);
        return (num_cores <= 1) ? 1 : $clog2(num_cores);
    endfunction

    function automatic int calc_gaddr_w(input int num_cores, input int core_addr_w);
        return calc_sel_w(num_cores) + core_addr_w;
    endfunction

    typedef struct packed {
        logic [MAX_SEL_W-1:0]       sel;
        logic [MAX_CORE_ADDR_W-1:0] addr;
    } fire_evt_t;

    typedef enum logic [0:0] {
        IN_IDLE = 1'b0,
        IN_WAIT = 1'b1
    } in_state_t;

endpackage

// File: rtl/ucaspian_mc_fifo.sv
// ----------------------------------------------------------------------------
// ucaspian_mc_fifo
//
// Purpose:
//   Synchronous FIFO of fire_evt_t records used to queue output fires from
//   the cores until the packet interface pops them.
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset (FIFO becomes empty)
//   push     in   write wr_data this cycle (ignored when full)
//   pop      in   drop the head entry this cycle (ignored when empty)
//   wr_data  in   record to write
//   rd_data  out  record at the head of the FIFO
//   full     out  DEPTH entries held
//   empty    out  no entries held
//
// DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module ucaspian_mc_fifo
    import ucaspian_mc_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  fire_evt_t wr_data,
    output fire_evt_t rd_data,
    output logic      full,
    output logic      empty
);

    fire_evt_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push_en;
    logic             pop_en;

    // Full and empty come from the registered count, so a pop in the same
    // cycle never makes room for a push into a full FIFO.
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage has no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_en && !pop_en) begin
                count <= count + 1'b1;
            end else if (!push_en && pop_en) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ucaspian_mc_router.sv
// ----------------------------------------------------------------------------
// ucaspian_mc_router
//
// Purpose:
//   Connects one packet_interface to NUM_CORES ucaspian_core instances.
//   Input fires are steered to a core by the upper global-address bits,
//   output fires from all cores are round-robin arbitrated into a FIFO and
//   tagged with their core index, and clear requests are broadcast with the
//   per-core completions merged into a single done pulse.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   host_in_waiting/addr/value, host_in_ack
//                            input fire from the interface, one-cycle ack
//   core_in_waiting          per-core input fire pending (one-hot)
//   core_in_addr/value       shared local address / value bus to cores
//   core_in_ack              per-core consume pulse
//   core_out_waiting/addr    per-core output fire, core i at slice i
//   core_out_sent            per-core capture pulse
//   host_out_waiting/addr    FIFO non-empty, {core index, local addr} head
//   host_out_sent            pop pulse from the interface
//   host_clear_act/config    clear requests, forwarded as core_clear_*
//   core_clear_done          per-core clear completion pulses
//   host_clear_done          pulse once every core has completed
//   core_active              per-core activity
//   host_core_active         registered OR of core_active
//   drop_count               (UCASPIAN_MC_DROP_CNT_EN only) saturating count
//                            of input fires dropped for an absent core
//
// Build option:
//   UCASPIAN_MC_DROP_CNT_EN  adds the drop_count port and counter.
// ----------------------------------------------------------------------------
module ucaspian_mc_router
    import ucaspian_mc_pkg::*;
#(
    parameter  int NUM_CORES   = 4,
    parameter  int CORE_ADDR_W = 6,
    parameter  int FIFO_DEPTH  = 4,
    localparam int SEL_W       = calc_sel_w(NUM_CORES),
    localparam int GADDR_W     = calc_gaddr_w(NUM_CORES, CORE_ADDR_W)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           host_in_waiting,
    input  logic [GADDR_W-1:0]             host_in_addr,
    input  logic [7:0]                     host_in_value,
    output logic                           host_in_ack,
    output logic [NUM_CORES-1:0]           core_in_waiting,
    output logic [CORE_ADDR_W-1:0]         core_in_addr,
    output logic [7:0]                     core_in_value,
    input  logic [NUM_CORES-1:0]           core_in_ack,
    input  logic [NUM_CORES-1:0]           core_out_waiting,
    input  logic [NUM_CORES*CORE_ADDR_W-1:0] core_out_addr,
    output logic [NUM_CORES-1:0]           core_out_sent,
    output logic                           host_out_waiting,
    output logic [GADDR_W-1:0]             host_out_addr,
    input  logic                           host_out_sent,
    input  logic                           host_clear_act,
    input  logic                           host_clear_config,
    output logic                           core_clear_act,
    output logic                           core_clear_config,
    input  logic [NUM_CORES-1:0]           core_clear_done,
    output logic                           host_clear_done,
    input  logic [NUM_CORES-1:0]           core_active,
    output logic                           host_core_active
`ifdef UCASPIAN_MC_DROP_CNT_EN
    ,
    output logic [15:0]                    drop_count
`endif
);

    function automatic int wrap_idx(input int v);
        return (v >= NUM_CORES) ? v - NUM_CORES : v;
    endfunction

    // ------------------------------------------------------------------
    // Input path
    // ------------------------------------------------------------------
    in_state_t              in_state;
    in_state_t              in_state_next;
    logic [SEL_W-1:0]       in_sel_q;
    logic [SEL_W-1:0]       in_sel_next;
    logic [CORE_ADDR_W-1:0] in_addr_q;
    logic [CORE_ADDR_W-1:0] in_addr_next;
    logic [7:0]             in_value_q;
    logic [7:0]             in_value_next;
    logic                   in_ack_next;
    logic                   in_drop;
    logic [SEL_W-1:0]       host_sel;
    logic                   host_sel_ok;
    logic [NUM_CORES-1:0]   in_sel_onehot;

    assign host_sel    = host_in_addr[GADDR_W-1:CORE_ADDR_W];
    assign host_sel_ok = (int'(host_sel) < NUM_CORES);

    always_comb begin
        in_sel_onehot = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            in_sel_onehot[i] = (int'(in_sel_q) == i);
        end
    end

    assign core_in_waiting = (in_state == IN_WAIT) ? in_sel_onehot : '0;
    assign core_in_addr    = in_addr_q;
    assign core_in_value   = in_value_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_state    <= IN_IDLE;
            in_sel_q    <= '0;
            in_addr_q   <= '0;
            in_value_q  <= '0;
            host_in_ack <= 1'b0;
        end else begin
            in_state    <= in_state_next;
            in_sel_q    <= in_sel_next;
            in_addr_q   <= in_addr_next;
            in_value_q  <= in_value_next;
            host_in_ack <= in_ack_next;
        end
    end

    // The interface still shows host_in_waiting during the ack cycle, so a
    // fire is only sampled when no ack is currently being presented.
    // Fires addressed beyond the last core are acked without a handshake.
    always_comb begin
        in_state_next = in_state;
        in_sel_next   = in_sel_q;
        in_addr_next  = in_addr_q;
        in_value_next = in_value_q;
        in_ack_next   = 1'b0;
        in_drop       = 1'b0;
        case (in_state)
            IN_IDLE: begin
                if (host_in_waiting && !host_in_ack) begin
                    if (host_sel_ok) begin
                        in_state_next = IN_WAIT;
                        in_sel_next   = host_sel;
                        in_addr_next  = host_in_addr[CORE_ADDR_W-1:0];
                        in_value_next = host_in_value;
                    end else begin
                        in_ack_next = 1'b1;
                        in_drop     = 1'b1;
                    end
                end
            end
            IN_WAIT: begin
                if (|(core_in_ack & in_sel_onehot)) begin
                    in_state_next = IN_IDLE;
                    in_ack_next   = 1'b1;
                end
            end
            default: begin
                in_state_next = IN_IDLE;
            end
        endcase
    end

`ifdef UCASPIAN_MC_DROP_CNT_EN
    // Saturating count of fires discarded for a non-existent core.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (in_drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = in_drop;
`endif

    // ------------------------------------------------------------------
    // Output path: round-robin arbiter feeding the fire FIFO
    // ------------------------------------------------------------------
    logic [SEL_W-1:0]       rr_ptr;
    logic [SEL_W-1:0]       rr_next;
    logic [NUM_CORES-1:0]   eligible;
    logic [NUM_CORES-1:0]   grant_vec;
    logic                   grant_valid;
    logic [SEL_W-1:0]       grant_idx;
    logic [CORE_ADDR_W-1:0] push_addr;
    fire_evt_t              push_evt;
    fire_evt_t              head_evt;
    logic                   fifo_full;
    logic                   fifo_empty;

    // A core granted last cycle still shows waiting while it reacts to its
    // sent pulse, so the registered sent vector doubles as the mask.
    always_comb begin
        eligible    = core_out_waiting & ~core_out_sent;
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_vec   = '0;
        push_addr   = '0;
        rr_next     = rr_ptr;
        if (!fifo_full) begin
            for (int k = 0; k < NUM_CORES; k++) begin
                if (!grant_valid && eligible[wrap_idx(int'(rr_ptr) + k)]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SEL_W'(wrap_idx(int'(rr_ptr) + k));
                    grant_vec[wrap_idx(int'(rr_ptr) + k)] = 1'b1;
                    push_addr   = core_out_addr[wrap_idx(int'(rr_ptr) + k)*CORE_ADDR_W +: CORE_ADDR_W];
                end
            end
        end
        if (grant_valid) begin
            rr_next = (int'(grant_idx) == NUM_CORES - 1) ? '0 : grant_idx + SEL_W'(1);
        end
        push_evt      = '0;
        push_evt.sel  = MAX_SEL_W'(grant_idx);
        push_evt.addr = MAX_CORE_ADDR_W'(push_addr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr        <= '0;
            core_out_sent <= '0;
        end else begin
            rr_ptr        <= rr_next;
            core_out_sent <= grant_vec;
        end
    end

    ucaspian_mc_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (grant_valid),
        .pop     (host_out_sent),
        .wr_data (push_evt),
        .rd_data (head_evt),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Head storage is not reset, so the address is forced to 0 when empty.
    logic unused_head;
    assign unused_head      = ^head_evt;
    assign host_out_waiting = !fifo_empty;
    assign host_out_addr    = fifo_empty ? '0 :
                              {head_evt.sel[SEL_W-1:0], head_evt.addr[CORE_ADDR_W-1:0]};

    // ------------------------------------------------------------------
    // Clear broadcast and completion aggregation, activity summary
    // ------------------------------------------------------------------
    logic [NUM_CORES-1:0] done_bits;
    logic [NUM_CORES-1:0] done_merged;

    assign done_merged = done_bits | core_clear_done;

    // A fresh request restarts aggregation; otherwise completions collect
    // until every core has reported, then one pulse goes to the host.
    always_ff @(posedge clk) begin
        if (reset) begin
            core_clear_act    <= 1'b0;
            core_clear_config <= 1'b0;
            host_clear_done   <= 1'b0;
            host_core_active  <= 1'b0;
            done_bits         <= '0;
        end else begin
            core_clear_act    <= host_clear_act;
            core_clear_config <= host_clear_config;
            host_core_active  <= |core_active;
            host_clear_done   <= 1'b0;
            if (host_clear_act || host_clear_config) begin
                done_bits <= '0;
            end else if (&done_merged) begin
                done_bits       <= '0;
                host_clear_done <= 1'b1;
            end else begin
                done_bits <= done_merged;
            end
        end
    end

endmodule

// File: tb/tb_ucaspian_mc_router.sv
`timescale 1ns/1ps
module tb_ucaspian_mc_router;

    localparam int NC    = 4;
    localparam int CAW   = 6;
    localparam int DEPTH = 4;
    localparam int GW    = 8;
    localparam int NC3   = 3;

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic              host_in_waiting;
    logic [GW-1:0]     host_in_addr;
    logic [7:0]        host_in_value;
    logic              host_in_ack;
    logic [NC-1:0]     core_in_waiting;
    logic [CAW-1:0]    core_in_addr;
    logic [7:0]        core_in_value;
    logic [NC-1:0]     core_in_ack;
    logic [NC-1:0]     core_out_waiting;
    logic [NC*CAW-1:0] core_out_addr;
    logic [NC-1:0]     core_out_sent;
    logic              host_out_waiting;
    logic [GW-1:0]     host_out_addr;
    logic              host_out_sent;
    logic              host_clear_act;
    logic              host_clear_config;
    logic              core_clear_act;
    logic              core_clear_config;
    logic [NC-1:0]     core_clear_done;
    logic              host_clear_done;
    logic [NC-1:0]     core_active;
    logic              host_core_active;

    logic               d3_host_in_waiting;
    logic [GW-1:0]      d3_host_in_addr;
    logic [7:0]         d3_host_in_value;
    logic               d3_host_in_ack;
    logic [NC3-1:0]     d3_core_in_waiting;
    logic [CAW-1:0]     d3_core_in_addr;
    logic [7:0]         d3_core_in_value;
    logic [NC3-1:0]     d3_core_in_ack;
    logic [NC3-1:0]     d3_core_out_waiting;
    logic [NC3*CAW-1:0] d3_core_out_addr;
    logic [NC3-1:0]     d3_core_out_sent;
    logic               d3_host_out_waiting;
    logic [GW-1:0]      d3_host_out_addr;
    logic               d3_host_out_sent;
    logic               d3_host_clear_act;
    logic               d3_host_clear_config;
    logic               d3_core_clear_act;
    logic               d3_core_clear_config;
    logic [NC3-1:0]     d3_core_clear_done;
    logic               d3_host_clear_done;
    logic [NC3-1:0]     d3_core_active;
    logic               d3_host_core_active;

`ifdef UCASPIAN_MC_DROP_CNT_EN
    logic [15:0] drop_count;
    logic [15:0] d3_drop_count;
`endif

    ucaspian_mc_router #(
        .NUM_CORES   (NC),
        .CORE_ADDR_W (CAW),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .host_in_waiting   (host_in_waiting),
        .host_in_addr      (host_in_addr),
        .host_in_value     (host_in_value),
        .host_in_ack       (host_in_ack),
        .core_in_waiting   (core_in_waiting),
        .core_in_addr      (core_in_addr),
        .core_in_value     (core_in_value),
        .core_in_ack       (core_in_ack),
        .core_out_waiting  (core_out_waiting),
        .core_out_addr     (core_out_addr),
        .core_out_sent     (core_out_sent),
        .host_out_waiting  (host_out_waiting),
        .host_out_addr     (host_out_addr),
        .host_out_sent     (host_out_sent),
        .host_clear_act    (host_clear_act),
        .host_clear_config (host_clear_config),
        .core_clear_act    (core_clear_act),
        .core_clear_config (core_clear_config),
        .core_clear_done   (core_clear_done),
        .host_clear_done   (host_clear_done),
        .core_active       (core_active),
        .host_core_active  (host_core_active)
`ifdef UCASPIAN_MC_DROP_CNT_EN
        ,
        .drop_count        (drop_count)
`endif
    );

    ucaspian_mc_router #(
        .NUM_CORES   (NC3),
        .CORE_ADDR_W (CAW),
        .FIFO_DEPTH  (DEPTH)
    ) dut3 (
        .clk               (clk),
        .reset             (reset),
        .host_in_waiting   (d3_host_in_waiting),
        .host_in_addr      (d3_host_in_addr),
        .host_in_value     (d3_host_in_value),
        .host_in_ack       (d3_host_in_ack),
        .core_in_waiting   (d3_core_in_waiting),
        .core_in_addr      (d3_core_in_addr),
        .core_in_value     (d3_core_in_value),
        .core_in_ack       (d3_core_in_ack),
        .core_out_waiting  (d3_core_out_waiting),
        .core_out_addr     (d3_core_out_addr),
        .core_out_sent     (d3_core_out_sent),
        .host_out_waiting  (d3_host_out_waiting),
        .host_out_addr     (d3_host_out_addr),
        .host_out_sent     (d3_host_out_sent),
        .host_clear_act    (d3_host_clear_act),
        .host_clear_config (d3_host_clear_config),
        .core_clear_act    (d3_core_clear_act),
        .core_clear_config (d3_core_clear_config),
        .core_clear_done   (d3_core_clear_done),
        .host_clear_done   (d3_host_clear_done),
        .core_active       (d3_core_active),
        .host_core_active  (d3_host_core_active)
`ifdef UCASPIAN_MC_DROP_CNT_EN
        ,
        .drop_count        (d3_drop_count)
`endif
    );

    // Advance one clock and land just after the edge, where outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        host_in_waiting      = 1'b0;
        host_in_addr         = '0;
        host_in_value        = '0;
        core_in_ack          = '0;
        core_out_waiting     = '0;
        core_out_addr        = '0;
        host_out_sent        = 1'b0;
        host_clear_act       = 1'b0;
        host_clear_config    = 1'b0;
        core_clear_done      = '0;
        core_active          = '0;
        d3_host_in_waiting   = 1'b0;
        d3_host_in_addr      = '0;
        d3_host_in_value     = '0;
        d3_core_in_ack       = '0;
        d3_core_out_waiting  = '0;
        d3_core_out_addr     = '0;
        d3_host_out_sent     = 1'b0;
        d3_host_clear_act    = 1'b0;
        d3_host_clear_config = 1'b0;
        d3_core_clear_done   = '0;
        d3_core_active       = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        core_active = '1;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({host_in_ack, core_in_waiting, core_in_addr, core_in_value, core_out_sent,
             host_out_waiting, host_out_addr, core_clear_act, core_clear_config,
             host_clear_done, host_core_active} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got ack=%0b ciw=%0h sent=%0h ow=%0b oa=%0h ca=%0b act=%0b required all 0",
                     host_in_ack, core_in_waiting, core_out_sent, host_out_waiting, host_out_addr,
                     core_clear_act, host_core_active);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (host_core_active !== 1'b1) begin
            failures++;
            $display("[TB] FAIL core_active_or: got %0b required 1", host_core_active);
        end
        core_active = 4'b0000;
        tick();
        checks++;
        if (host_core_active !== 1'b0) begin
            failures++;
            $display("[TB] FAIL core_active_idle: got %0b required 0", host_core_active);
        end
    endtask

    task automatic test_input_route();
        do_reset();
        host_in_waiting = 1'b1;
        host_in_addr    = 8'h85;
        host_in_value   = 8'h3C;
        tick();
        checks++;
        if ({core_in_waiting, core_in_addr, core_in_value} !== {4'b0100, 6'h05, 8'h3C}) begin
            failures++;
            $display("[TB] FAIL route_0x85: got w=%b a=%0h v=%0h required w=0100 a=5 v=3c",
                     core_in_waiting, core_in_addr, core_in_value);
        end
        core_in_ack = 4'b1011;
        tick();
        checks++;
        if ({host_in_ack, core_in_waiting} !== {1'b0, 4'b0100}) begin
            failures++;
            $display("[TB] FAIL foreign_ack_ignored: got ack=%0b w=%b required ack=0 w=0100",
                     host_in_ack, core_in_waiting);
        end
        core_in_ack = 4'b0100;
        tick();
        checks++;
        if ({host_in_ack, core_in_waiting} !== {1'b1, 4'b0000}) begin
            failures++;
            $display("[TB] FAIL ack_pulse: got ack=%0b w=%b required ack=1 w=0000",
                     host_in_ack, core_in_waiting);
        end
        core_in_ack = '0;
        tick();
        checks++;
        if ({host_in_ack, core_in_waiting} !== {1'b0, 4'b0000}) begin
            failures++;
            $display("[TB] FAIL no_double_accept: got ack=%0b w=%b required ack=0 w=0000",
                     host_in_ack, core_in_waiting);
        end
        host_in_waiting = 1'b0;
        tick();
    endtask

    task automatic test_input_random();
        logic [7:0]    a;
        logic [7:0]    v;
        int            sel;
        int            lat;
        logic [NC-1:0] onehot;
        do_reset();
        for (int t = 0; t < 10; t++) begin
            a      = 8'($urandom_range(0, 255));
            v      = 8'($urandom_range(0, 255));
            lat    = int'($urandom_range(0, 3));
            sel    = int'(a) / 64;
            onehot = NC'(1) << sel;
            host_in_waiting = 1'b1;
            host_in_addr    = a;
            host_in_value   = v;
            core_in_ack     = '0;
            tick();
            checks++;
            if ({core_in_waiting, core_in_addr, core_in_value} !== {onehot, 6'(int'(a) % 64), v}) begin
                failures++;
                $display("[TB] FAIL rand_route: addr=%0h got w=%b a=%0h v=%0h required w=%b a=%0h v=%0h",
                         a, core_in_waiting, core_in_addr, core_in_value, onehot, int'(a) % 64, v);
            end
            for (int l = 0; l < lat; l++) begin
                core_in_ack = NC'($urandom_range(0, 15)) & ~onehot;
                tick();
                checks++;
                if ({host_in_ack, core_in_waiting} !== {1'b0, onehot}) begin
                    failures++;
                    $display("[TB] FAIL rand_hold: got ack=%0b w=%b required ack=0 w=%b",
                             host_in_ack, core_in_waiting, onehot);
                end
            end
            core_in_ack = onehot | NC'($urandom_range(0, 15));
            tick();
            checks++;
            if (host_in_ack !== 1'b1) begin
                failures++;
                $display("[TB] FAIL rand_ack: got %0b required 1", host_in_ack);
            end
            core_in_ack     = '0;
            host_in_waiting = 1'b0;
            tick();
            checks++;
            if ({host_in_ack, core_in_waiting} !== {1'b0, 4'b0000}) begin
                failures++;
                $display("[TB] FAIL rand_release: got ack=%0b w=%b required ack=0 w=0000",
                         host_in_ack, core_in_waiting);
            end
        end
    endtask

    task automatic test_fifo_fill();
        int         cnt [NC];
        logic [7:0] exp_q [4];
        exp_q = '{8'h01, 8'h42, 8'h83, 8'hC4};
        do_reset();
        for (int i = 0; i < NC; i++) begin
            cnt[i] = 0;
            core_out_addr[i*CAW +: CAW] = CAW'(i + 1);
        end
        core_out_waiting = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            tick();
            for (int i = 0; i < NC; i++) begin
                if (core_out_sent[i]) cnt[i]++;
            end
        end
        for (int i = 0; i < NC; i++) begin
            checks++;
            if (cnt[i] != 1) begin
                failures++;
                $display("[TB] FAIL fill_sent_count core%0d: got %0d required 1", i, cnt[i]);
            end
        end
        core_out_waiting = '0;
        for (int e = 0; e < 4; e++) begin
            checks++;
            if ({host_out_waiting, host_out_addr} !== {1'b1, exp_q[e]}) begin
                failures++;
                $display("[TB] FAIL fill_entry%0d: got w=%0b addr=%0h required w=1 addr=%0h",
                         e, host_out_waiting, host_out_addr, exp_q[e]);
            end
            host_out_sent = 1'b1;
            tick();
            host_out_sent = 1'b0;
        end
        checks++;
        if (host_out_waiting !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fill_drained: got %0b required 0", host_out_waiting);
        end
    endtask

    task automatic test_rr_alternate();
        logic [NC-1:0] exp_sent;
        logic [7:0]    exp_head;
        do_reset();
        core_out_addr[1*CAW +: CAW] = 6'h11;
        core_out_addr[3*CAW +: CAW] = 6'h33;
        core_out_waiting = 4'b1010;
        host_out_sent    = 1'b1;
        for (int n = 0; n < 8; n++) begin
            tick();
            exp_sent = (n % 2 == 0) ? 4'b0010 : 4'b1000;
            exp_head = (n % 2 == 0) ? 8'h51 : 8'hF3;
            checks++;
            if ({core_out_sent, host_out_waiting, host_out_addr} !== {exp_sent, 1'b1, exp_head}) begin
                failures++;
                $display("[TB] FAIL rr_alt%0d: got sent=%b w=%0b addr=%0h required sent=%b w=1 addr=%0h",
                         n, core_out_sent, host_out_waiting, host_out_addr, exp_sent, exp_head);
            end
        end
        core_out_waiting = '0;
        host_out_sent    = 1'b0;
    endtask

    task automatic test_drop();
        do_reset();
        d3_host_in_waiting = 1'b1;
        d3_host_in_addr    = 8'hC0;
        d3_host_in_value   = 8'h55;
        tick();
        d3_host_in_waiting = 1'b0;
        checks++;
        if ({d3_host_in_ack, d3_core_in_waiting} !== {1'b1, 3'b000}) begin
            failures++;
            $display("[TB] FAIL drop_ack: got ack=%0b w=%b required ack=1 w=000",
                     d3_host_in_ack, d3_core_in_waiting);
        end
        tick();
        checks++;
        if ({d3_host_in_ack, d3_core_in_waiting} !== {1'b0, 3'b000}) begin
            failures++;
            $display("[TB] FAIL drop_after: got ack=%0b w=%b required ack=0 w=000",
                     d3_host_in_ack, d3_core_in_waiting);
        end
`ifdef UCASPIAN_MC_DROP_CNT_EN
        checks++;
        if (d3_drop_count !== 16'd1) begin
            failures++;
            $display("[TB] FAIL drop_count: got %0d required 1", d3_drop_count);
        end
`endif
        d3_host_in_waiting = 1'b1;
        d3_host_in_addr    = 8'h83;
        tick();
        d3_host_in_waiting = 1'b0;
        checks++;
        if ({d3_host_in_ack, d3_core_in_waiting, d3_core_in_addr} !== {1'b0, 3'b100, 6'h03}) begin
            failures++;
            $display("[TB] FAIL d3_valid_route: got ack=%0b w=%b a=%0h required ack=0 w=100 a=3",
                     d3_host_in_ack, d3_core_in_waiting, d3_core_in_addr);
        end
        d3_core_in_ack = 3'b100;
        tick();
        d3_core_in_ack = '0;
        tick();
    endtask

    task automatic test_clear();
        do_reset();
        for (int c = 0; c <= 13; c++) begin
            checks++;
            if ({core_clear_act, host_clear_done} !== {1'(c == 1), 1'(c == 10)}) begin
                failures++;
                $display("[TB] FAIL clear_cycle%0d: got fwd=%0b done=%0b required fwd=%0b done=%0b",
                         c, core_clear_act, host_clear_done, c == 1, c == 10);
            end
            host_clear_act  = (c == 0);
            core_clear_done = '0;
            if (c == 3) core_clear_done[0] = 1'b1;
            if (c == 7) core_clear_done[1] = 1'b1;
            if (c == 5) core_clear_done[2] = 1'b1;
            if (c == 9) core_clear_done[3] = 1'b1;
            tick();
        end
        for (int c = 0; c <= 10; c++) begin
            checks++;
            if ({core_clear_config, core_clear_act, host_clear_done} !==
                {1'(c == 1), 1'(c == 5), 1'(c == 8)}) begin
                failures++;
                $display("[TB] FAIL restart_cycle%0d: got cfg=%0b act=%0b done=%0b required cfg=%0b act=%0b done=%0b",
                         c, core_clear_config, core_clear_act, host_clear_done, c == 1, c == 5, c == 8);
            end
            host_clear_config = (c == 0);
            host_clear_act    = (c == 4);
            core_clear_done   = '0;
            if (c == 2) core_clear_done = 4'b0111;
            if (c == 5) core_clear_done = 4'b1000;
            if (c == 7) core_clear_done = 4'b1111;
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        host_in_waiting  = 1'b1;
        host_in_addr     = 8'h85;
        host_in_value    = 8'h3C;
        core_out_addr    = {6'h04, 6'h03, 6'h02, 6'h01};
        core_out_waiting = 4'b0011;
        tick();
        tick();
        core_out_waiting = '0;
        reset = 1'b1;
        tick();
        checks++;
        if ({host_in_ack, core_in_waiting, core_in_addr, core_in_value, core_out_sent,
             host_out_waiting, host_out_addr, core_clear_act, core_clear_config,
             host_clear_done, host_core_active} !== '0) begin
            failures++;
            $display("[TB] FAIL midflight_reset: got ack=%0b w=%b sent=%b ow=%0b oa=%0h required all 0",
                     host_in_ack, core_in_waiting, core_out_sent, host_out_waiting, host_out_addr);
        end
        reset           = 1'b0;
        host_in_waiting = 1'b0;
        core_in_ack     = 4'b0100;
        tick();
        core_in_ack = '0;
        tick();
        checks++;
        if ({host_in_ack, host_out_waiting} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL stale_ack: got ack=%0b ow=%0b required ack=0 ow=0",
                     host_in_ack, host_out_waiting);
        end
    endtask

    task automatic test_random_output();
        logic [GW-1:0] q [$];
        int            rr;
        logic [NC-1:0] m_sent;
        logic [NC-1:0] exp_sent;
        logic [GW-1:0] exp_head;
        bit            was_full;
        bit            was_nonempty;
        int            g;
        int            i;
        do_reset();
        q.delete();
        rr     = 0;
        m_sent = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            core_out_waiting = NC'($urandom_range(0, 15));
            for (int c = 0; c < NC; c++) begin
                core_out_addr[c*CAW +: CAW] = CAW'($urandom);
            end
            if (cyc < 150) host_out_sent = ($urandom_range(0, 3) == 0);
            else           host_out_sent = ($urandom_range(0, 3) != 0);
            was_full     = (q.size() == DEPTH);
            was_nonempty = (q.size() > 0);
            g = -1;
            if (!was_full) begin
                for (int k = 0; k < NC; k++) begin
                    i = (rr + k) % NC;
                    if (g < 0 && core_out_waiting[i] && !m_sent[i]) g = i;
                end
            end
            exp_sent = '0;
            if (host_out_sent && was_nonempty) void'(q.pop_front());
            if (g >= 0) begin
                q.push_back({2'(g), core_out_addr[g*CAW +: CAW]});
                exp_sent[g] = 1'b1;
                rr = (g + 1) % NC;
            end
            m_sent = exp_sent;
            tick();
            exp_head = (q.size() > 0) ? q[0] : '0;
            checks++;
            if ({core_out_sent, host_out_waiting, host_out_addr} !==
                {exp_sent, 1'(q.size() > 0), exp_head}) begin
                failures++;
                $display("[TB] FAIL rand_out cyc%0d: got sent=%b w=%0b addr=%0h required sent=%b w=%0b addr=%0h",
                         cyc, core_out_sent, host_out_waiting, host_out_addr,
                         exp_sent, q.size() > 0, exp_head);
            end
        end
        core_out_waiting = '0;
        host_out_sent    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_input_route();
        test_input_random();
        test_fifo_fill();
        test_rr_alternate();
        test_drop();
        test_clear();
        test_reset_midflight();
        test_random_output();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
